// File: rtl/bch_error_sched.sv
// ============================================================================
// bch_error_sched: sequences one BCH codeword through a single-error search
// engine and streams per-word error bits with first/last/uncorrectable flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bch_error_sched #(
  parameter int M         = 4,
  parameter int DATA_BITS = 11,
  parameter int BITS      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*M-1:0]    sigma,
  output logic              eng_start,
  output logic [2*M-1:0]    eng_sigma,
  input  logic              eng_first,
  input  logic [BITS-1:0]   eng_err,
  output logic              out_valid,
  output logic [BITS-1:0]   out_err,
  output logic              out_first,
  output logic              out_last,
  output logic              uncorrectable
);

  localparam int WORDS     = (DATA_BITS + BITS - 1) / BITS;
  localparam int CW        = $clog2(WORDS) + 1;
  localparam int LAST_BITS = DATA_BITS - (WORDS - 1) * BITS;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_STREAM = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_tally;
  logic            r_zero;
  logic [2*M-1:0]  r_sigma;

  logic            w_accept;
  logic            w_active;
  logic [CW-1:0]   w_word;
  logic            w_last;
  logic [BITS-1:0] w_err;
  logic [1:0]      w_tally;

  // Word 0 of an engine-driven codeword is emitted in the WAIT cycle that sees eng_first.
  always_comb begin
    w_accept = in_valid && (r_state == S_IDLE);
    w_active = (r_state == S_STREAM) || ((r_state == S_WAIT) && eng_first);
    w_word   = (r_state == S_WAIT) ? '0 : r_cnt;
    w_last   = w_active && (w_word == LAST_WORD);
    w_err    = '0;
    for (int b = 0; b < BITS; b++) begin
      w_err[b] = w_active && !r_zero && eng_err[b] && !(w_last && (b >= LAST_BITS));
    end
    w_tally = r_tally;
    for (int b = 0; b < BITS; b++) begin
      if (w_err[b] && (w_tally != 2'd2)) w_tally = w_tally + 2'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_next = (sigma == '0) ? S_STREAM : S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (eng_first) w_next = w_last ? S_IDLE : S_STREAM;
      S_STREAM: if (w_last) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tally <= 2'd0;
      r_zero  <= 1'b0;
      r_sigma <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_sigma <= sigma;
        r_zero  <= (sigma == '0);
        r_cnt   <= '0;
        r_tally <= 2'd0;
      end else if (w_active) begin
        r_cnt   <= w_word + CW'(1);
        r_tally <= w_tally;
      end
    end
  end

  assign in_ready      = (r_state == S_IDLE);
  assign eng_start     = (r_state == S_LAUNCH);
  assign eng_sigma     = r_sigma;
  assign out_valid     = w_active;
  assign out_err       = w_err;
  assign out_first     = w_active && (w_word == '0);
  assign out_last      = w_last;
  assign uncorrectable = w_last && (w_tally == 2'd2);

endmodule

`default_nettype wire
